phase_bus_responder: RTL

Card-side responder for the phase bus: the board end of the host's write4/read4/adc4 command sequences. It decodes BOARD_X, AddessPortPin and the active-low RdP/WrP strobes, commits writes into card registers, and drives read data back onto the bus. It also runs the multiplexer-set / ADC-convert sequence the host triggers with two write pulses to the mux port. It sits in the card/loopback model opposite the host command state machines.

---
 rtl/phase_bus_pkg.sv | 40 ++++
 rtl/strobe_sync.sv | 34 +++
 rtl/phase_bus_responder.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/phase_bus_pkg.sv
// Shared definitions for the phase bus responder: port codes, board codes,
// strobe/direction encodings, bus word layout and the ADC sequencer states.
package phase_bus_pkg;

  localparam logic [2:0] PORT_LATCH    = 3'd0;
  localparam logic [2:0] PORT_ADC_HIGH = 3'd1;
  localparam logic [2:0] PORT_ADC_LOW  = 3'd2;
  localparam logic [2:0] PORT_MUX      = 3'd3;
  localparam logic [2:0] PORT_STATUS   = 3'd4;

  // Broadcast board code: accepted for writes, never answered for reads.
  localparam logic [3:0] BOARD_ALL = 4'd5;

  // Bus strobes are active-low.
  typedef enum logic {ENABLE = 1'b0, DISABLE = 1'b1} en_mode_t;

  // Direction of the shared data bus as seen from the card.
  typedef enum logic {DIR_IN = 1'b0, DIR_OUT = 1'b1} dir_mode_t;

  typedef enum logic [1:0] {
    ADC_IDLE,
    ADC_ARMED,
    ADC_CONVERT,
    ADC_CAPTURE
  } adc_state_t;

  // Non-strobe bus inputs, synchronized together as one word.
  typedef struct packed {
    logic [3:0] board;
    logic [2:0] port;
    logic       test;
    logic [7:0] data;
  } bus_word_t;

  function automatic logic [7:0] status_byte(input logic overrun, input logic proto_err,
                                             input logic valid, input logic busy);
    return {4'b0000, overrun, proto_err, valid, busy};
  endfunction

endpackage

// File: rtl/strobe_sync.sv
// Multi-stage synchronizer for a single asynchronous control input, with
// one-cycle rise/fall pulses derived from the synchronized level.
module strobe_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic din,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  // Shift the raw input through the chain and keep the previous synced level.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      chain <= {STAGES{RESET_VAL}};
      prev  <= RESET_VAL;
    end else begin
      chain <= {chain[STAGES-2:0], din};
      prev  <= chain[STAGES-1];
    end
  end

  assign q    = chain[STAGES-1];
  assign rise = q & ~prev;
  assign fall = ~q & prev;

endmodule

// File: rtl/phase_bus_responder.sv
// Card-side phase bus responder: decodes host strobes, commits writes to the
// output latch and ADC mux port, returns read data, and sequences the ADC.
module phase_bus_responder
  import phase_bus_pkg::*;
#(
  parameter int unsigned CLOCK_FREQUENCY = 27000000,
  parameter logic [3:0]  BOARD_ID        = 4'd1,     // must not be BOARD_ALL
  parameter int          SYNC_STAGES     = 2,
  parameter int          ADC_CONV_CYCLES = 20
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  BOARD_X,
  input  logic [2:0]  AddessPortPin,
  input  logic        RdP,
  input  logic        WrP,
  input  logic        TestAddressP,
  input  logic        LampResetPin,
  input  logic [7:0]  Data_In_Port,
  output logic [7:0]  Data_Out_Port,
  output logic        data_oe,
  output logic [7:0]  latch_out,
  output logic [7:0]  mux_sel,
  output logic        adc_start,
  input  logic [15:0] adc_sample
);

  localparam int unsigned unused_clock_hz = CLOCK_FREQUENCY;
  localparam int CNT_W = $clog2(ADC_CONV_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ADC_CONV_CYCLES - 1);

  logic rd_q, rd_rise, rd_fall;
  logic wr_q, wr_rise, unused_wr_fall;
  logic lamp_q, unused_lamp_rise, unused_lamp_fall;

  bus_word_t                   bus_in, bus_s;
  bus_word_t [SYNC_STAGES-1:0] bus_chain;

  logic [3:0] wr_board;
  logic [2:0] wr_port;
  logic [7:0] wr_data;

  logic       lockout, conflict, access_ok, rd_match, commit, mux_write;
  dir_mode_t  bus_dir;
  logic [7:0] rd_value;

  logic [15:0]      result;
  logic             busy, valid, proto_err, overrun;
  adc_state_t       state, next_state;
  logic             load_mux, start_conv, capture;
  logic [CNT_W-1:0] cnt;

  strobe_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_rd_sync (
    .clock(clock), .reset(reset), .din(RdP), .q(rd_q), .rise(rd_rise), .fall(rd_fall));
  strobe_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_wr_sync (
    .clock(clock), .reset(reset), .din(WrP), .q(wr_q), .rise(wr_rise), .fall(unused_wr_fall));
  strobe_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_lamp_sync (
    .clock(clock), .reset(reset), .din(LampResetPin), .q(lamp_q),
    .rise(unused_lamp_rise), .fall(unused_lamp_fall));

  assign bus_in = {BOARD_X, AddessPortPin, TestAddressP, Data_In_Port};
  assign bus_s  = bus_chain[SYNC_STAGES-1];

  // Plain synchronizer chain for the address/board/data bus.
  // NOTE: this flop chain is small and feeds decode logic, so it is reset to keep decode deterministic.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) bus_chain <= '0;
    else        bus_chain <= {bus_chain[SYNC_STAGES-2:0], bus_in};
  end

  // Hold the write target from the last cycle the synced write strobe was low.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_board <= '0;
      wr_port  <= '0;
      wr_data  <= '0;
    end else if (wr_q == ENABLE) begin
      wr_board <= bus_s.board;
      wr_port  <= bus_s.port;
      wr_data  <= bus_s.data;
    end
  end

  // After a simultaneous read/write, ignore the bus until both strobes are idle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                                      lockout <= 1'b0;
    else if (conflict)                               lockout <= 1'b1;
    else if (rd_q == DISABLE && wr_q == DISABLE)     lockout <= 1'b0;
  end

  assign conflict  = (rd_q == ENABLE) && (wr_q == ENABLE);
  assign access_ok = !conflict && !lockout;
  assign rd_match  = (bus_s.board == BOARD_ID);
  assign commit    = wr_rise && access_ok && (wr_board == BOARD_ID || wr_board == BOARD_ALL);
  assign mux_write = commit && (wr_port == PORT_MUX);
  assign data_oe   = (bus_dir == DIR_OUT);

  // Select the value a read of the addressed port returns.
  always_comb begin
    rd_value = 8'h00;
    case (bus_s.port)
      PORT_LATCH:    rd_value = latch_out;
      PORT_ADC_HIGH: rd_value = result[15:8];
      PORT_ADC_LOW:  rd_value = result[7:0];
      PORT_STATUS:   rd_value = status_byte(overrun, proto_err, valid, busy);
      default:       rd_value = 8'h00;
    endcase
    if (bus_s.test) rd_value = {4'hA, BOARD_ID};
  end

  // ADC sequencer state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= ADC_IDLE;
    else        state <= next_state;
  end

  // ADC sequencer next-state and control strobes.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    next_state = state;
    load_mux   = 1'b0;
    start_conv = 1'b0;
    capture    = 1'b0;
    case (state)
      ADC_IDLE:    if (mux_write) begin load_mux = 1'b1; next_state = ADC_ARMED; end
      ADC_ARMED:   if (mux_write) begin start_conv = 1'b1; next_state = ADC_CONVERT; end
      ADC_CONVERT: if (cnt == CNT_LAST) next_state = ADC_CAPTURE;
      ADC_CAPTURE: begin capture = 1'b1; next_state = ADC_IDLE; end
      default:     next_state = ADC_IDLE;
    endcase
  end

  // Registers, read snapshot, status bits and conversion counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      Data_Out_Port <= 8'h00;
      bus_dir       <= DIR_IN;
      latch_out     <= 8'h00;
      mux_sel       <= 8'h00;
      adc_start     <= 1'b0;
      result        <= 16'h0000;
      busy          <= 1'b0;
      valid         <= 1'b0;
      proto_err     <= 1'b0;
      overrun       <= 1'b0;
      cnt           <= '0;
    end else begin
      adc_start <= start_conv;

      if (lamp_q == ENABLE)                       latch_out <= 8'h00;
      else if (commit && wr_port == PORT_LATCH)   latch_out <= wr_data;

      if (load_mux) mux_sel <= wr_data;

      // Side effects of a read apply only to real register reads, not identity probes.
      if (conflict) begin
        bus_dir <= DIR_IN;
      end else if (rd_fall && !lockout && rd_match) begin
        Data_Out_Port <= rd_value;
        bus_dir       <= DIR_OUT;
        if (!bus_s.test && bus_s.port == PORT_ADC_LOW) valid <= 1'b0;
        if (!bus_s.test && bus_s.port == PORT_STATUS) begin
          overrun   <= 1'b0;
          proto_err <= 1'b0;
        end
      end else if (rd_rise) begin
        bus_dir <= DIR_IN;
      end

      if (conflict)                              proto_err <= 1'b1;
      if (mux_write && state == ADC_CONVERT)     overrun   <= 1'b1;
      if (start_conv)                            busy      <= 1'b1;

      // Capture comes last so it wins over a same-cycle low-byte read.
      if (capture) begin
        result <= adc_sample;
        valid  <= 1'b1;
        busy   <= 1'b0;
      end

      if (start_conv)                 cnt <= '0;
      else if (state == ADC_CONVERT)  cnt <= cnt + 1'b1;
    end
  end

endmodule
